pbox_feeder: RTL

- Producer end of the NMS predicted-box interface: drives pred_bbox_data and advances to the next box on each rising edge of pbox_ready from NMS_Module.
- Boxes arrive on an AXI4-Stream slave port from the DMA/host side and are buffered in a small synchronous FIFO.
- The next box is prefetched into a head register, so the first box of a frame is stable before NMS starts.
- Signals frame completion when the tlast-marked box has been consumed.

---
 rtl/nms_pkg.sv | 17 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/pbox_feeder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nms_pkg.sv
// Shared NMS definitions: box geometry/score layout and interface widths.
// Used by the predicted-box feeder and by NMS_Module itself.
package nms_pkg;

    localparam int BBOX_DATA_WIDTH = 64;
    localparam int BBOX_IND_WIDTH  = 14;
    localparam int FIFO_ADDR_WIDTH = 4;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
        logic [15:0] score;
    } bbox_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational read of the oldest entry.
// Latency: a pushed entry is visible on rdata the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no full-bypass.
module sync_fifo #(
    parameter int WIDTH      = 65,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                 DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pbox_feeder.sv
// Feeds buffered AXIS boxes to NMS, one per rising edge of pbox_ready.
// Latency: empty-path box shows 2 edges after acceptance; advance shows next edge.
// Backpressure: s_tready drops when the FIFO is full; a held-high request advances once.
module pbox_feeder #(
    parameter int BBOX_DATA_WIDTH = nms_pkg::BBOX_DATA_WIDTH,
    parameter int FIFO_ADDR_WIDTH = nms_pkg::FIFO_ADDR_WIDTH,
    parameter int BBOX_IND_WIDTH  = nms_pkg::BBOX_IND_WIDTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic [BBOX_DATA_WIDTH-1:0] s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    input  logic                       pbox_ready,
    output nms_pkg::bbox_t             pred_bbox_data,
    output logic                       head_valid,
    output logic                       frame_done,
    output logic                       underflow_err,
    output logic [BBOX_IND_WIDTH-1:0]  box_count
);

    import nms_pkg::*;

    localparam int ENTRY_W = BBOX_DATA_WIDTH + 1;
    localparam logic [BBOX_IND_WIDTH-1:0] CNT_ONE = BBOX_IND_WIDTH'(1);

    logic                       fifo_full, fifo_empty;
    logic [FIFO_ADDR_WIDTH:0]   fifo_level_unused;
    logic [ENTRY_W-1:0]         fifo_rdata;
    logic                       push, pop, adv, consume;

    logic [BBOX_DATA_WIDTH-1:0] head_dat_q, head_dat_d;
    logic                       head_vld_q, head_vld_d;
    logic                       head_last_q, head_last_d;
    logic                       frame_done_q, frame_done_d;
    logic                       underflow_err_q, underflow_err_d;
    logic [BBOX_IND_WIDTH-1:0]  box_count_q, box_count_d;
    logic                       pbox_ready_q, pbox_ready_d;

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .push   (push),
        .pop    (pop),
        .wdata  ({s_tlast, s_tdata}),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_level_unused)
    );

    assign s_tready       = ~fifo_full;
    assign push           = s_tvalid & ~fifo_full;
    assign pred_bbox_data = bbox_t'(head_dat_q);
    assign head_valid     = head_vld_q;
    assign frame_done     = frame_done_q;
    assign underflow_err  = underflow_err_q;
    assign box_count      = box_count_q;

    always_comb begin
        adv     = pbox_ready & ~pbox_ready_q;
        consume = adv & head_vld_q;
        // Refill the head whenever it is empty or being consumed this cycle.
        pop     = ~fifo_empty & (~head_vld_q | adv);

        head_dat_d      = head_dat_q;
        head_vld_d      = head_vld_q;
        head_last_d     = head_last_q;
        underflow_err_d = underflow_err_q;
        box_count_d     = box_count_q;
        pbox_ready_d    = pbox_ready;
        frame_done_d    = consume & head_last_q;

        if (consume) begin
            box_count_d = box_count_q + CNT_ONE;
        end
        if (adv & ~head_vld_q) begin
            underflow_err_d = 1'b1;
        end

        if (pop) begin
            head_dat_d  = fifo_rdata[BBOX_DATA_WIDTH-1:0];
            head_last_d = fifo_rdata[BBOX_DATA_WIDTH];
            head_vld_d  = 1'b1;
        end else if (consume) begin
            head_vld_d  = 1'b0;
        end

        // Flush mirrors reset; pbox_ready_q forced high so a held request is not an edge.
        if (flush) begin
            head_dat_d      = '0;
            head_vld_d      = 1'b0;
            head_last_d     = 1'b0;
            frame_done_d    = 1'b0;
            underflow_err_d = 1'b0;
            box_count_d     = '0;
            pbox_ready_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_dat_q      <= '0;
            head_vld_q      <= 1'b0;
            head_last_q     <= 1'b0;
            frame_done_q    <= 1'b0;
            underflow_err_q <= 1'b0;
            box_count_q     <= '0;
            pbox_ready_q    <= 1'b1;
        end else begin
            head_dat_q      <= head_dat_d;
            head_vld_q      <= head_vld_d;
            head_last_q     <= head_last_d;
            frame_done_q    <= frame_done_d;
            underflow_err_q <= underflow_err_d;
            box_count_q     <= box_count_d;
            pbox_ready_q    <= pbox_ready_d;
        end
    end

endmodule
